// File: rtl/sram_rd_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sram_rd_arbiter
// Brief   : Round-robin arbiter sharing the SRAM read port between IFU and LSU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_rd_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   input  logic [ADDR_W-1:0] ifu_araddr,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              sram_arvalid,
   input  logic              sram_arready,
   output logic [ADDR_W-1:0] sram_araddr,
   input  logic              sram_rvalid,
   output logic              sram_rready,
   input  logic [DATA_W-1:0] sram_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic grant_ifu;
   logic grant_lsu;
   logic in_data;
   logic owner_rready;

   // Grants are gated by reset so every output reads 0 while reset is held.
   assign grant_ifu = reset && (state_q == IDLE) && ifu_arvalid &&
                      (!lsu_arvalid || (last_grant_q == MST_LSU));
   assign grant_lsu = reset && (state_q == IDLE) && lsu_arvalid &&
                      (!ifu_arvalid || (last_grant_q == MST_IFU));

   assign in_data      = (state_q == DATA);
   assign owner_rready = (owner_q == MST_LSU) ? lsu_rready : ifu_rready;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      case (state_q)
         IDLE: begin
            if (grant_ifu || grant_lsu) begin
               addr_d       = grant_lsu ? lsu_araddr : ifu_araddr;
               owner_d      = grant_lsu ? MST_LSU : MST_IFU;
               last_grant_d = grant_lsu ? MST_LSU : MST_IFU;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            if (sram_arready) state_d = DATA;
         end
         DATA: begin
            if (sram_rvalid && owner_rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= MST_IFU;
         last_grant_q <= MST_IFU;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
      end
   end

   assign ifu_arready  = grant_ifu;
   assign lsu_arready  = grant_lsu;

   assign sram_arvalid = (state_q == ADDR);
   assign sram_araddr  = addr_q;
   assign sram_rready  = in_data && owner_rready;

   // Data is forwarded to the owner even while rvalid is low; the other master sees zeros.
   assign ifu_rvalid   = in_data && (owner_q == MST_IFU) && sram_rvalid;
   assign lsu_rvalid   = in_data && (owner_q == MST_LSU) && sram_rvalid;
   assign ifu_rdata    = (in_data && (owner_q == MST_IFU)) ? sram_rdata : '0;
   assign lsu_rdata    = (in_data && (owner_q == MST_LSU)) ? sram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_sram_rd_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_rd_arbiter
// Brief   : Randomized transaction-level bench for sram_rd_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_rd_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam logic [63:0] C_TAG = 64'hC3A5_5A3C_0F0F_F0F0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ifu_arvalid = 1'b0, ifu_arready, ifu_rvalid, ifu_rready = 1'b0;
   logic [AW-1:0] ifu_araddr = '0;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_arvalid = 1'b0, lsu_arready, lsu_rvalid, lsu_rready = 1'b0;
   logic [AW-1:0] lsu_araddr = '0;
   logic [DW-1:0] lsu_rdata;
   logic          sram_arvalid, sram_arready = 1'b0, sram_rvalid = 1'b0, sram_rready;
   logic [AW-1:0] sram_araddr;
   logic [DW-1:0] sram_rdata = '0;

   always #5 clk = ~clk;

   sram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
      .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
      .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
      .sram_arvalid(sram_arvalid), .sram_arready(sram_arready), .sram_araddr(sram_araddr),
      .sram_rvalid(sram_rvalid), .sram_rready(sram_rready), .sram_rdata(sram_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: one transaction in flight, owner, last winner, address.
   bit          m_busy, m_ar_done, m_owner, m_last;
   logic [63:0] m_addr;
   // Master stimulus: pending request, awaiting data, expected data.
   bit          pend [2];
   bit          wait_r [2];
   logic [63:0] req_addr [2];
   logic [63:0] want [2];
   // SRAM responder.
   bit          s_has, s_valid;
   int          s_lat;
   logic [63:0] s_addr;
   int          grants [2];

   function automatic logic [63:0] mem(input logic [63:0] a);
      return a ^ C_TAG;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_ar_done = 0; m_owner = 0; m_last = 0; m_addr = '0;
      for (int m = 0; m < 2; m++) begin pend[m] = 0; wait_r[m] = 0; end
      s_has = 0; s_valid = 0; s_lat = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ifu_arready"}, 64'(ifu_arready), 64'd0);
      check({tag, "_lsu_arready"}, 64'(lsu_arready), 64'd0);
      check({tag, "_ifu_rvalid"},  64'(ifu_rvalid), 64'd0);
      check({tag, "_lsu_rvalid"},  64'(lsu_rvalid), 64'd0);
      check({tag, "_ifu_rdata"},   ifu_rdata, 64'd0);
      check({tag, "_lsu_rdata"},   lsu_rdata, 64'd0);
      check({tag, "_sram_arvalid"}, 64'(sram_arvalid), 64'd0);
      check({tag, "_sram_araddr"}, sram_araddr, 64'd0);
      check({tag, "_sram_rready"}, 64'(sram_rready), 64'd0);
   endtask

   task automatic drive_inputs();
      for (int m = 0; m < 2; m++)
         if (!pend[m] && !wait_r[m] && ($urandom_range(0, 99) < 60)) begin
            pend[m]     = 1;
            req_addr[m] = {$urandom, $urandom};
         end
      ifu_arvalid = pend[0];
      ifu_araddr  = pend[0] ? req_addr[0] : {$urandom, $urandom};
      lsu_arvalid = pend[1];
      lsu_araddr  = pend[1] ? req_addr[1] : {$urandom, $urandom};
      ifu_rready  = ($urandom_range(0, 99) < 65);
      lsu_rready  = ($urandom_range(0, 99) < 65);
      sram_arready = ($urandom_range(0, 99) < 55);
      if (s_has && !s_valid) begin
         if (s_lat > 0) s_lat--;
         else s_valid = 1;
      end
      sram_rvalid = s_valid;
      sram_rdata  = s_valid ? mem(s_addr) : {$urandom, $urandom};
   endtask

   task automatic check_cycle();
      bit e_ifu_ar, e_lsu_ar, in_d, o_rr;
      e_ifu_ar = !m_busy && pend[0] && (!pend[1] || m_last == 1'b1);
      e_lsu_ar = !m_busy && pend[1] && (!pend[0] || m_last == 1'b0);
      in_d = m_busy && m_ar_done;
      o_rr = m_owner ? lsu_rready : ifu_rready;
      check("ifu_arready",  64'(ifu_arready), 64'(e_ifu_ar));
      check("lsu_arready",  64'(lsu_arready), 64'(e_lsu_ar));
      check("sram_arvalid", 64'(sram_arvalid), 64'(m_busy && !m_ar_done));
      check("sram_araddr",  sram_araddr, m_addr);
      check("sram_rready",  64'(sram_rready), 64'(in_d && o_rr));
      check("ifu_rvalid",   64'(ifu_rvalid), 64'(in_d && !m_owner && sram_rvalid));
      check("lsu_rvalid",   64'(lsu_rvalid), 64'(in_d && m_owner && sram_rvalid));
      check("ifu_rdata",    ifu_rdata, (in_d && !m_owner) ? sram_rdata : 64'd0);
      check("lsu_rdata",    lsu_rdata, (in_d && m_owner) ? sram_rdata : 64'd0);

      // Advance the model by the handshakes that fire on the coming edge.
      if (e_ifu_ar || e_lsu_ar) begin
         m_owner = e_lsu_ar;
         m_last  = e_lsu_ar;
         m_addr  = req_addr[m_owner];
         m_busy  = 1; m_ar_done = 0;
         pend[m_owner]   = 0;
         wait_r[m_owner] = 1;
         want[m_owner]   = mem(req_addr[m_owner]);
         grants[m_owner]++;
      end else if (m_busy && !m_ar_done && sram_arready) begin
         m_ar_done = 1;
         s_has = 1; s_valid = 0; s_addr = sram_araddr;
         s_lat = $urandom_range(0, 3);
      end else if (in_d && sram_rvalid && o_rr) begin
         check(m_owner ? "lsu_e2e_data" : "ifu_e2e_data",
               m_owner ? lsu_rdata : ifu_rdata, want[m_owner]);
         wait_r[m_owner] = 0;
         m_busy = 0; m_ar_done = 0;
         s_has = 0; s_valid = 0;
      end
   endtask

   initial begin
      bit did_mid_reset;
      did_mid_reset = 0;
      grants[0] = 0; grants[1] = 0;
      model_reset();

      // Outputs must stay quiet under reset even with live requests.
      ifu_arvalid = 1; lsu_arvalid = 1; ifu_rready = 1; lsu_rready = 1;
      sram_arready = 1; sram_rvalid = 1; sram_rdata = 64'hDEAD_BEEF_0000_0001;
      #12;
      check_all_zero("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1;

      // First tie after reset goes to the LSU.
      pend[0] = 1; req_addr[0] = 64'h1000;
      pend[1] = 1; req_addr[1] = 64'h2000;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive_inputs();
         #1;
         if (cyc == 0)
            check("first_tie_lsu", {62'd0, lsu_arready, ifu_arready}, 64'b10);
         if (!did_mid_reset && cyc > 1500 && m_busy && m_ar_done) begin
            // Abort mid-transaction with an asynchronous reset between edges.
            did_mid_reset = 1;
            #1 reset = 0;
            #1;
            check_all_zero("midrst");
            model_reset();
            ifu_arvalid = 0; lsu_arvalid = 0; sram_rvalid = 0;
            @(negedge clk);
            @(negedge clk);
            reset = 1;
            continue;
         end
         check_cycle();
         @(negedge clk);
      end

      check("mid_reset_done", 64'(did_mid_reset), 64'd1);
      check("ifu_served", 64'(grants[0] > 20), 64'd1);
      check("lsu_served", 64'(grants[1] > 20), 64'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
